// File: rtl/bcd_down_counter_if.sv
// Load/count bundle for bcd_down_counter. The testbench drives it as master;
// the counter connects as slave.
interface bcd_down_counter_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  en;
  logic [4*DIGITS-1:0]   count;
  logic                  zero;
  logic                  done;
  logic                  busy;
  logic                  load_err;

  modport master (
    output load, load_val, en,
    input  count, zero, done, busy, load_err
  );

  modport slave (
    input  load, load_val, en,
    output count, zero, done, busy, load_err
  );
endinterface

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter with load, expiry detection and load clamping.
// Optional macro BCD_DOWN_COUNTER_AUTO_RELOAD_EN restarts the count from the last load after expiry.
module bcd_down_counter #(
  parameter int DIGITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  bcd_down_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_EXPIRED} state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_count, w_count_nxt;
  logic           r_zero, w_zero_nxt;
  logic           r_done, w_done_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_load_err, w_load_err_nxt;
  logic [W-1:0]   w_dec;
  logic [W-1:0]   w_clamped;
  logic           w_bad_digit;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
  logic [W-1:0]   r_reload, w_reload_nxt;
`endif

  function automatic logic [W-1:0] f_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  function automatic logic f_has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  // Borrow ripples upward: every zero digit below the first non-zero one wraps to 9.
  function automatic logic [W-1:0] f_bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign w_dec       = f_bcd_dec(r_count);
  assign w_clamped   = f_clamp(bus.load_val);
  assign w_bad_digit = f_has_bad_digit(bus.load_val);

  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_zero_nxt     = r_zero;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
    w_reload_nxt   = r_reload;
`endif
    if (bus.load) begin
      w_count_nxt    = w_clamped;
      w_load_err_nxt = w_bad_digit;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
      w_reload_nxt   = w_clamped;
`endif
      if (w_clamped != '0) begin
        w_state_nxt = ST_RUN;
        w_busy_nxt  = 1'b1;
        w_zero_nxt  = 1'b0;
      end else begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
        w_zero_nxt  = 1'b1;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.en) begin
            w_count_nxt = w_dec;
            if (w_dec == '0) begin
              w_state_nxt = ST_EXPIRED;
              w_zero_nxt  = 1'b1;
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
            end
          end
        end
        ST_EXPIRED: begin
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
          // A zero reload value leaves the counter parked in EXPIRED.
          if (bus.en && (r_reload != '0)) begin
            w_count_nxt = r_reload;
            w_state_nxt = ST_RUN;
            w_busy_nxt  = 1'b1;
            w_zero_nxt  = 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_zero     <= 1'b1;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_load_err <= 1'b0;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload   <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_zero     <= w_zero_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
      r_load_err <= w_load_err_nxt;
`ifdef BCD_DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload   <= w_reload_nxt;
`endif
    end
  end

  assign bus.count    = r_count;
  assign bus.zero     = r_zero;
  assign bus.done     = r_done;
  assign bus.busy     = r_busy;
  assign bus.load_err = r_load_err;
endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
Multi-digit decimal (BCD) down-counter. It is the countdown counterpart of the existing decade up-counter.
- Loads a BCD start value, then decrements once per enabled clock, with borrow rippling across digits.
- Stops at zero and flags expiry.
- Used as a countdown timer feeding display and control logic. Counts share the up-counter's 4-bit-per-digit BCD format.

Parameters:
DIGITS, 2, number of BCD digits; count width is 4*DIGITS.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
load  input  1  synchronous load strobe
load_val  input  4*DIGITS  BCD start value, digit 0 in bits [3:0]
en  input  1  count enable, one decrement per cycle while high in RUN
count  output  4*DIGITS  current BCD value, registered
zero  output  1  high when count == 0, registered
done  output  1  one-cycle pulse on the cycle count becomes 0 by decrement
busy  output  1  high in RUN state
load_err  output  1  one-cycle pulse when load_val held a digit > 9

Behaviour:
- Reset (reset==0, asynchronous):
  - count=0, zero=1, done=0, busy=0, load_err=0, state=IDLE.
  - Takes effect immediately, including mid-count.
  - Release is synchronous to the next clk edge.
- States:
  - IDLE: count held; waiting for load.
  - RUN: decrementing.
  - EXPIRED: count==0 reached by decrement; held until next load.
- Load, from any state:
  - Takes effect the cycle after the load edge: count <= load_val.
  - Any digit > 9 is clamped to 9 and load_err pulses for one cycle.
  - If the loaded value != 0: next state RUN, busy=1, zero=0.
  - If the loaded value == 0: next state IDLE, zero=1, no done pulse.
- Priority: load > en. With load and en high in the same cycle, the value loads and no decrement occurs that cycle.
- RUN with en=1 decrements by 1 (BCD):
  - Digit i decrements only if all lower digits were 0; those lower digits wrap 0 -> 9.
  - Example: 100 -> 099.
- RUN with en=0: count holds, state stays RUN.
- Reaching zero: when the decrement takes count from 1 to 0, then on that same edge:
  - zero=1, done=1 for exactly one cycle, busy=0;
  - state goes to EXPIRED.
- EXPIRED: en is ignored. Count never goes below 0 (no wrap to 99..9).
- Latency: one clk from strobe to updated count. All outputs are registered; no combinational path from input to output.

Optional Feature:
- Macro: BCD_DOWN_COUNTER_AUTO_RELOAD_EN.
- When defined:
  - The last successfully loaded (post-clamp) value is kept in a reload register.
  - On the decrement to zero, done pulses and zero is 1 for that cycle, as normal.
  - On the next enabled cycle, count is reloaded from the register and the state returns to RUN instead of EXPIRED.
  - A reload value of 0 behaves as if the macro were undefined.
  - Reset clears the reload register to 0.
- When undefined: no reload register; behaviour exactly as described above.

Test Plan:
- Reset pulse low for 10 time units mid-count (count=57) -> count=00, zero=1, busy=0 immediately, before the next clk edge.
- Load 05, en held high -> count 05,04,03,02,01,00 on consecutive cycles; done high only on the 00 cycle; then holds 00, state EXPIRED, busy=0.
- DIGITS=3, load 100, en=1 -> next count 099; load 010 -> 009; verifies the borrow ripple and 0->9 wrap.
- Load 3F (digit 0 = 0xF) -> count=39, load_err one-cycle pulse; load and en asserted together -> value loaded, not decremented.
- en toggled 1,0,0,1 from 20 -> 19,19,19,18; load 00 -> zero=1, no done pulse, state IDLE.
- With BCD_DOWN_COUNTER_AUTO_RELOAD_EN defined, load 03, en=1 -> 03,02,01,00(done),03,02..., periodic done every 4 cycles.
